// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The source drives A/B/Cin/in_valid and the consumer drives out_ready; the adder is the slave.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] S;
   logic             Cout;
   logic             Ovf;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output A, B, Cin, in_valid, out_ready,
      input  in_ready, S, Cout, Ovf, out_valid
   );

   modport slave (
      input  A, B, Cin, in_valid, out_ready,
      output in_ready, S, Cout, Ovf, out_valid
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a registered carry, LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           reset,
   serial_adder_if.slave bus
);
   localparam int            CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_next;
   logic [WIDTH-1:0] s_q;
   logic             carry;
   logic             carry_msb;
   logic             cout_q;
   logic [CW-1:0]    count;

   logic             fa_s;
   logic             fa_p;
   logic             fa_g;
   logic             fa_co;
   logic             accept;
   logic             last;

   // Single-bit carry-look-ahead full-adder cell on the current bit pair.
   always_comb begin
      fa_p  = a_sh[0] ^ b_sh[0];
      fa_g  = a_sh[0] & b_sh[0];
      fa_s  = fa_p ^ carry;
      fa_co = fa_g | (carry & fa_p);
   end

   // Sum enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
   always_comb begin
      sum_next            = sum_sh >> 1;
      sum_next[WIDTH-1]   = fa_s;
   end

   assign accept = (state == IDLE) && bus.in_valid;
   assign last   = (count == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               state_next = ADD;
            end
         end
         ADD: begin
            if (last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_sh      <= '0;
         b_sh      <= '0;
         sum_sh    <= '0;
         carry     <= 1'b0;
         count     <= '0;
         carry_msb <= 1'b0;
         s_q       <= '0;
         cout_q    <= 1'b0;
      end else if (accept) begin
         a_sh  <= bus.A;
         b_sh  <= bus.B;
         carry <= bus.Cin;
         count <= '0;
      end else if (state == ADD) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         sum_sh <= sum_next;
         carry  <= fa_co;
         count  <= count + CW'(1);
         // Result registers only move on the final bit, so they hold through IDLE and the next add.
         if (last) begin
            carry_msb <= carry;
            s_q       <= sum_next;
            cout_q    <= fa_co;
         end
      end
   end

   assign bus.S    = s_q;
   assign bus.Cout = cout_q;
   assign bus.Ovf  = carry_msb ^ cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases at WIDTH=8 plus
// randomized scoreboard regression at WIDTH=1, 8 and 16.
module tb_serial_adder;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- WIDTH=8 instance ----------------
   serial_adder_if #(.WIDTH(8)) bus8 ();
   serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

   logic [9:0] sb8[$];

   function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
      logic [8:0] full;
      logic       ovf;
      full = {1'b0, a} + {1'b0, b} + {8'd0, c};
      ovf  = (a[7] == b[7]) && (full[7] != a[7]);
      return {ovf, full};
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         sb8.delete();
      end else if (bus8.in_valid && bus8.in_ready) begin
         sb8.push_back(model8(bus8.A, bus8.B, bus8.Cin));
      end
   end

   always @(negedge clk) begin
      if (!reset && bus8.out_valid && bus8.out_ready) begin
         if (sb8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL w8 unexpected result: got %0h, expected none", {bus8.Ovf, bus8.Cout, bus8.S});
         end else begin
            check("w8 result {Ovf,Cout,S}", {bus8.Ovf, bus8.Cout, bus8.S}, sb8.pop_front());
         end
      end
   end

   // ---------------- WIDTH=1 and WIDTH=16 random instances ----------------
   for (genvar gi = 0; gi < 2; gi++) begin : g_rand
      localparam int W = (gi == 0) ? 1 : 16;
      logic rst_g;
      logic done = 1'b0;
      logic [W+1:0] sb[$];

      serial_adder_if #(.WIDTH(W)) bus ();
      serial_adder #(.WIDTH(W)) dut (.clk(clk), .reset(rst_g), .bus(bus));

      function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
         logic [W:0] full;
         full = {1'b0, a} + {1'b0, b} + (W+1)'(c);
         return {(a[W-1] == b[W-1]) && (full[W-1] != a[W-1]), full};
      endfunction

      always @(negedge clk) begin
         if (rst_g) begin
            sb.delete();
         end else if (bus.in_valid && bus.in_ready) begin
            sb.push_back(model(bus.A, bus.B, bus.Cin));
         end
      end

      always @(negedge clk) begin
         if (!rst_g && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL w%0d unexpected result: got %0h, expected none", W, {bus.Ovf, bus.Cout, bus.S});
            end else begin
               check($sformatf("w%0d result {Ovf,Cout,S}", W), {bus.Ovf, bus.Cout, bus.S}, sb.pop_front());
            end
         end
      end

      initial begin
         int   sent;
         int   budget;
         logic acc;
         sent         = 0;
         budget       = 0;
         rst_g        = 1'b1;
         bus.in_valid = 1'b0;
         bus.out_ready = 1'b0;
         bus.A        = '0;
         bus.B        = '0;
         bus.Cin      = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         rst_g = 1'b0;
         while ((sent < 1000 || sb.size() != 0) && budget < 60000) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            budget++;
            if (acc) begin
               bus.in_valid = 1'b0;
               sent++;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid && sent < 1000 && $urandom_range(0, 1) == 1) begin
               bus.A        = W'($urandom);
               bus.B        = W'($urandom);
               bus.Cin      = 1'($urandom);
               bus.in_valid = 1'b1;
            end
         end
         check($sformatf("w%0d random run completed", W), budget < 60000, 1);
         done = 1'b1;
      end
   end

   // ---------------- WIDTH=8 directed helpers ----------------
   task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
      int n;
      n = 0;
      while (!bus8.in_ready && n < 50) begin
         tick();
         n++;
      end
      check("w8 in_ready before send", bus8.in_ready, 1);
      bus8.A        = a;
      bus8.B        = b;
      bus8.Cin      = c;
      bus8.in_valid = 1'b1;
      tick();
      bus8.in_valid = 1'b0;
      bus8.A        = 8'($urandom);
      bus8.B        = 8'($urandom);
      bus8.Cin      = 1'($urandom);
   endtask

   task automatic wait_done8(output int lat, output int busy_ready);
      lat        = 0;
      busy_ready = 0;
      while (!bus8.out_valid && lat < 40) begin
         if (bus8.in_ready) busy_ready++;
         tick();
         lat++;
      end
      if (bus8.in_ready) busy_ready++;
   endtask

   task automatic consume8();
      bus8.out_ready = 1'b1;
      tick();
      bus8.out_ready = 1'b0;
      check("w8 in_ready after consume", bus8.in_ready, 1);
      check("w8 out_valid after consume", bus8.out_valid, 0);
   endtask

   task automatic run_random8(input int n);
      int   sent;
      int   budget;
      logic acc;
      sent   = 0;
      budget = 0;
      while ((sent < n || sb8.size() != 0) && budget < n * 40) begin
         @(negedge clk);
         acc = bus8.in_valid && bus8.in_ready;
         @(posedge clk);
         #1;
         budget++;
         if (acc) begin
            bus8.in_valid = 1'b0;
            sent++;
         end
         bus8.out_ready = ($urandom_range(0, 3) != 0);
         if (!bus8.in_valid && sent < n && $urandom_range(0, 1) == 1) begin
            bus8.A        = 8'($urandom);
            bus8.B        = 8'($urandom);
            bus8.Cin      = 1'($urandom);
            bus8.in_valid = 1'b1;
         end
      end
      bus8.out_ready = 1'b0;
      check("w8 random run completed", budget < n * 40, 1);
   endtask

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic [7:0] s;
      logic       co;
      logic       ov;
   } vec_t;

   vec_t corner[5];

   initial begin
      int lat;
      int busy;
      int guard;
      int acc_c[$];
      int ov_c[$];

      corner[0] = '{a: 8'h0F, b: 8'h01, c: 1'b0, s: 8'h10, co: 1'b0, ov: 1'b0};
      corner[1] = '{a: 8'hFF, b: 8'h01, c: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b0};
      corner[2] = '{a: 8'h7F, b: 8'h01, c: 1'b0, s: 8'h80, co: 1'b0, ov: 1'b1};
      corner[3] = '{a: 8'h80, b: 8'h80, c: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b1};
      corner[4] = '{a: 8'hFF, b: 8'hFF, c: 1'b1, s: 8'hFF, co: 1'b1, ov: 1'b0};

      reset          = 1'b1;
      bus8.A         = '0;
      bus8.B         = '0;
      bus8.Cin       = 1'b0;
      bus8.in_valid  = 1'b0;
      bus8.out_ready = 1'b0;
      tick();
      tick();
      check("reset in_ready", bus8.in_ready, 1);
      check("reset out_valid", bus8.out_valid, 0);
      check("reset S", bus8.S, 0);
      check("reset Cout", bus8.Cout, 0);
      check("reset Ovf", bus8.Ovf, 0);
      reset = 1'b0;

      // Basic add and carry/overflow corners.
      for (int i = 0; i < 5; i++) begin
         send8(corner[i].a, corner[i].b, corner[i].c);
         wait_done8(lat, busy);
         check($sformatf("corner%0d latency", i), lat, 8);
         check($sformatf("corner%0d in_ready while busy", i), busy, 0);
         check($sformatf("corner%0d S", i), bus8.S, corner[i].s);
         check($sformatf("corner%0d Cout", i), bus8.Cout, corner[i].co);
         check($sformatf("corner%0d Ovf", i), bus8.Ovf, corner[i].ov);
         consume8();
      end

      // Backpressure: result must hold while the source toggles.
      send8(8'h3C, 8'h55, 1'b1);
      wait_done8(lat, busy);
      check("bp latency", lat, 8);
      for (int k = 0; k < 6; k++) begin
         bus8.A        = 8'($urandom);
         bus8.B        = 8'($urandom);
         bus8.in_valid = 1'($urandom);
         tick();
         check("bp hold S", bus8.S, 8'h92);
         check("bp hold Cout", bus8.Cout, 0);
         check("bp hold Ovf", bus8.Ovf, 1);
         check("bp hold out_valid", bus8.out_valid, 1);
         check("bp no accept", bus8.in_ready, 0);
      end
      bus8.in_valid = 1'b0;
      consume8();

      // Reset after three ADD cycles aborts the add.
      send8(8'h11, 8'h22, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort in_ready", bus8.in_ready, 1);
      check("abort out_valid", bus8.out_valid, 0);
      check("abort S", bus8.S, 0);
      check("abort Cout", bus8.Cout, 0);
      check("abort Ovf", bus8.Ovf, 0);
      for (int k = 0; k < 12; k++) begin
         tick();
         check("abort result never valid", bus8.out_valid, 0);
      end
      send8(8'h05, 8'h03, 1'b0);
      wait_done8(lat, busy);
      check("post-abort S", bus8.S, 8'h08);
      consume8();

      // Back-to-back with in_valid and out_ready held high.
      bus8.A         = 8'($urandom);
      bus8.B         = 8'($urandom);
      bus8.Cin       = 1'($urandom);
      bus8.in_valid  = 1'b1;
      bus8.out_ready = 1'b1;
      for (int cyc = 0; cyc < 52; cyc++) begin
         @(negedge clk);
         if (bus8.in_ready) acc_c.push_back(cyc);
         if (bus8.out_valid) ov_c.push_back(cyc);
         @(posedge clk);
         #1;
         bus8.A   = 8'($urandom);
         bus8.B   = 8'($urandom);
         bus8.Cin = 1'($urandom);
      end
      bus8.in_valid = 1'b0;
      check("b2b accept count", acc_c.size(), 6);
      check("b2b result count", ov_c.size(), 5);
      for (int i = 0; i + 1 < acc_c.size(); i++) begin
         check($sformatf("b2b accept spacing %0d", i), acc_c[i+1] - acc_c[i], 10);
      end
      for (int i = 0; i < ov_c.size() && i < acc_c.size(); i++) begin
         check($sformatf("b2b result timing %0d", i), ov_c[i] - acc_c[i], 9);
      end
      guard = 0;
      while (!bus8.in_ready && guard < 30) begin
         tick();
         guard++;
      end
      check("b2b drain", bus8.in_ready, 1);
      bus8.out_ready = 1'b0;

      run_random8(1000);
      check("w8 scoreboard empty", sb8.size(), 0);

      guard = 0;
      while (!(g_rand[0].done && g_rand[1].done) && guard < 80000) begin
         tick();
         guard++;
      end
      check("random blocks completed", g_rand[0].done && g_rand[1].done, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
